// File: rtl/serial_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_bus_pkg
// Brief   : Shared constants and state type for the 1-bit serial system bus
//           responder.
// Revision: 1.0 - initial release
// ============================================================================
package serial_bus_pkg;

  // Transaction type carried on the mode line with the first address bit
  localparam logic BUS_MODE_READ  = 1'b0;
  localparam logic BUS_MODE_WRITE = 1'b1;

  // Responder protocol states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WDATA   = 3'd2,
    ST_MEM_WR  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RDATA   = 3'd5
  } slave_state_t;

endpackage : serial_bus_pkg
`default_nettype wire

// File: rtl/slave_bram.sv
`default_nettype none
// ============================================================================
// Module  : slave_bram
// Brief   : Single-port synchronous RAM, registered read, write-enable.
//           The array has no reset so it maps onto block RAM.
// Revision: 1.0 - initial release
// ============================================================================
module slave_bram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write when enabled; read every cycle (old data on a same-address write)
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule : slave_bram
`default_nettype wire

// File: rtl/serial_mem_slave.sv
`default_nettype none
// ============================================================================
// Module  : serial_mem_slave
// Brief   : Memory target on the 1-bit serial system bus. Deserialises
//           address / write data from wr_bus, commits writes to a local RAM
//           and serialises read data on rd_bus with a valid/ready handshake.
//           Optional transaction counters: define SERIAL_SLAVE_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module serial_mem_slave
  import serial_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mode,
  input  logic        wr_bus,
  input  logic        master_valid,
  output logic        slave_ready,
  output logic        rd_bus,
  output logic        slave_valid,
  input  logic        master_ready
`ifdef SERIAL_SLAVE_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
`endif
);

  // One counter serves address bits, data bits and the read wait
  localparam int MAX_N = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2((MAX_N > 16) ? MAX_N : 16);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(READ_LATENCY - 1);

  slave_state_t          state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd_sh_q;
  logic                  slave_valid_q;
  logic                  slave_ready_q;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Address shifts in LSB first from the top; after ADDR_WIDTH bits the first
  // bit sits at position 0. The RAM is addressed with the next-state value so
  // the read is launched on the same edge that completes the address.
  always_comb begin
    addr_d = addr_q;
    if (((state_q == ST_IDLE) || (state_q == ST_ADDR)) && master_valid) begin
      addr_d = {wr_bus, addr_q[ADDR_WIDTH-1:1]};
    end
  end

  assign mem_we = (state_q == ST_MEM_WR);

  slave_bram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (addr_d),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Protocol FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mode_q        <= BUS_MODE_READ;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_sh_q       <= '0;
      slave_valid_q <= 1'b0;
      slave_ready_q <= 1'b1;
    end else begin
      addr_q <= addr_d;
      case (state_q)
        ST_IDLE: begin
          if (master_valid) begin
            mode_q        <= mode;
            cnt_q         <= CNT_W'(1);
            slave_ready_q <= 1'b0;
            state_q       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!master_valid) begin
            cnt_q         <= '0;
            slave_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else if (cnt_q == LAST_ADDR) begin
            cnt_q   <= '0;
            state_q <= (mode_q == BUS_MODE_WRITE) ? ST_WDATA : ST_RD_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WDATA: begin
          if (!master_valid) begin
            cnt_q         <= '0;
            slave_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            wdata_q <= {wr_bus, wdata_q[DATA_WIDTH-1:1]};
            if (cnt_q == LAST_DATA) begin
              cnt_q   <= '0;
              state_q <= ST_MEM_WR;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_MEM_WR: begin
          slave_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (cnt_q == LAST_WAIT) begin
            cnt_q         <= '0;
            rd_sh_q       <= mem_rdata;
            slave_valid_q <= 1'b1;
            state_q       <= ST_RDATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RDATA: begin
          if (master_ready) begin
            if (cnt_q == LAST_DATA) begin
              cnt_q         <= '0;
              rd_sh_q       <= '0;
              slave_valid_q <= 1'b0;
              slave_ready_q <= 1'b1;
              state_q       <= ST_IDLE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              rd_sh_q <= {1'b0, rd_sh_q[DATA_WIDTH-1:1]};
            end
          end
        end
        default: begin
          cnt_q         <= '0;
          rd_sh_q       <= '0;
          slave_valid_q <= 1'b0;
          slave_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  // rd_bus is the shift register LSB, which is zero whenever not in RDATA
  assign rd_bus      = rd_sh_q[0];
  assign slave_valid = slave_valid_q;
  assign slave_ready = slave_ready_q;

`ifdef SERIAL_SLAVE_STATS_EN
  logic [15:0] wr_count_q;
  logic [15:0] rd_count_q;

  // Count committed writes and fully delivered reads, wrapping at 16 bits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      if (state_q == ST_MEM_WR) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if ((state_q == ST_RDATA) && master_ready && (cnt_q == LAST_DATA)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
`endif

endmodule : serial_mem_slave
`default_nettype wire

// File: tb/tb_serial_mem_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_mem_slave
// Brief   : Self-checking bench for serial_mem_slave: directed scenarios plus
//           randomized writes/reads against an array-based memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_mem_slave;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rstn;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic master_ready;
  logic slave_ready;
  logic rd_bus;
  logic slave_valid;
`ifdef SERIAL_SLAVE_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
`endif

  serial_mem_slave #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .rd_bus       (rd_bus),
    .slave_valid  (slave_valid),
    .master_ready (master_ready)
`ifdef SERIAL_SLAVE_STATS_EN
    ,
    .wr_count     (wr_count),
    .rd_count     (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: word array plus the list of addresses holding known data
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] written_q [$];
  int ref_wr_cnt;
  int ref_rd_cnt;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full or aborted write; abort_at = number of bits sent before valid drops
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int abort_at);
    logic [AW+DW-1:0] bits;
    bits = {d, a};
    @(negedge clk);
    check("wr_idle_ready", slave_ready, 1);
    mode = 1'b1;
    for (int i = 0; i < AW + DW; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) check("wr_busy_ready", slave_ready, 0);
      if (i == abort_at) begin
        master_valid = 1'b0;
        wr_bus       = 1'($urandom);
        @(negedge clk);
        check("wr_abort_ready", slave_ready, 1);
        return;
      end
      master_valid = 1'b1;
      wr_bus       = bits[i];
      if (i > 0) mode = 1'($urandom);
    end
    @(negedge clk);
    master_valid = 1'($urandom);
    check("wr_memwr_ready", slave_ready, 0);
    @(negedge clk);
    master_valid = 1'b0;
    check("wr_done_ready", slave_ready, 1);
    ref_mem[a] = d;
    written_q.push_back(a);
    ref_wr_cnt++;
  endtask

  // Read with optional fixed stall at one bit, random stalls, or reset at a bit
  task automatic do_read(input logic [AW-1:0] a, input int stall_bit, input int stall_len,
                         input int rst_bit, input bit rand_stall);
    logic [DW-1:0] exp;
    logic [DW-1:0] got;
    int idx;
    int vcycles;
    int stalls;
    exp = ref_mem[a];
    got = '0;
    idx = 0;
    vcycles = 0;
    stalls = 0;
    @(negedge clk);
    check("rd_idle_ready", slave_ready, 1);
    mode = 1'b0;
    for (int i = 0; i < AW; i++) begin
      if (i > 0) @(negedge clk);
      master_valid = 1'b1;
      wr_bus       = a[i];
      if (i > 0) mode = 1'($urandom);
    end
    for (int w = 0; w < RL; w++) begin
      @(negedge clk);
      master_valid = 1'($urandom);
      master_ready = 1'($urandom);
      check("rd_wait_valid", slave_valid, 0);
    end
    for (int c = 0; c < 200 && idx < DW; c++) begin
      @(negedge clk);
      check("rd_valid", slave_valid, 1);
      check("rd_bit", rd_bus, exp[idx]);
      vcycles += int'(slave_valid);
      if (idx == rst_bit) begin
        rstn = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        #1;
        check("rst_valid", slave_valid, 0);
        check("rst_rd_bus", rd_bus, 0);
        check("rst_ready", slave_ready, 1);
        @(negedge clk);
        check("rst_hold_ready", slave_ready, 1);
        rstn = 1'b1;
        ref_wr_cnt = 0;
        ref_rd_cnt = 0;
        return;
      end
      master_valid = 1'($urandom);
      if (idx == stall_bit && stalls < stall_len) begin
        master_ready = 1'b0;
        stalls++;
      end else if (rand_stall && $urandom_range(3) == 0) begin
        master_ready = 1'b0;
      end else begin
        master_ready = 1'b1;
      end
      if (master_ready && slave_valid) begin
        got[idx] = rd_bus;
        idx++;
      end
    end
    if (idx < DW) check("rd_timeout_bits", idx, DW);
    @(negedge clk);
    master_valid = 1'b0;
    master_ready = 1'b0;
    check("rd_done_valid", slave_valid, 0);
    check("rd_done_bus", rd_bus, 0);
    check("rd_done_ready", slave_ready, 1);
    check("rd_data", got, exp);
    if (!rand_stall) check("rd_valid_cycles", vcycles, DW + stall_len);
    ref_rd_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    ref_wr_cnt = 0;
    ref_rd_cnt = 0;
    rstn = 1'b0;
    mode = 1'b0;
    wr_bus = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", slave_ready, 1);
    check("reset_valid", slave_valid, 0);
    check("reset_rd_bus", rd_bus, 0);
`ifdef SERIAL_SLAVE_STATS_EN
    check("reset_wr_count", wr_count, 0);
    check("reset_rd_count", rd_count, 0);
`endif
    rstn = 1'b1;

    // Write then read, then read with a 3-cycle stall on bit 4
    do_write(12'h3C7, 8'hA5, -1);
    do_read(12'h3C7, -1, 0, -1, 1'b0);
    do_read(12'h3C7, 4, 3, -1, 1'b0);

    // Write abort after 5 data bits leaves the earlier value in place
    do_write(12'h010, 8'h3C, -1);
    do_write(12'h010, 8'hFF, AW + 5);
    do_read(12'h010, -1, 0, -1, 1'b0);
    check("abort_model", ref_mem[12'h010], 8'h3C);

    // Reset during read data, then re-read the stored word
    do_read(12'h3C7, -1, 0, 2, 1'b0);
`ifdef SERIAL_SLAVE_STATS_EN
    check("post_rst_wr_count", wr_count, 0);
    check("post_rst_rd_count", rd_count, 0);
`endif
    do_read(12'h3C7, -1, 0, -1, 1'b0);

    // Address extremes
    do_write(12'hFFF, 8'hFF, -1);
    do_write(12'h000, 8'h00, -1);
    do_read(12'hFFF, -1, 0, -1, 1'b0);
    do_read(12'h000, -1, 0, -1, 1'b0);

    // Randomized traffic with aborts and random read stalls
    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(9));
      if (op < 4) begin
        do_write(AW'($urandom_range(63) * 64 + $urandom_range(3)), DW'($urandom), -1);
      end else if (op == 4) begin
        do_write(AW'($urandom), DW'($urandom), int'($urandom_range(AW + DW - 1, 1)));
      end else begin
        do_read(written_q[$urandom_range(written_q.size() - 1)], -1, 0, -1, 1'b1);
      end
    end

`ifdef SERIAL_SLAVE_STATS_EN
    repeat (2) @(negedge clk);
    check("stats_wr_count", wr_count, 16'(ref_wr_cnt));
    check("stats_rd_count", rd_count, 16'(ref_rd_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_mem_slave
`default_nettype wire
